// File: rtl/fixed_point_divider_if.sv
// Start/done handshake bundle for the sequential signed fixed-point divider.
// The master side drives operands and start; the slave side returns the quotient and status.
interface fixed_point_divider_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] result;
  logic             overflow_flag;
  logic             busy;
  logic             done;

  modport master (
    output start, A, B,
    input  result, overflow_flag, busy, done
  );

  modport slave (
    input  start, A, B,
    output result, overflow_flag, busy, done
  );
endinterface

// File: rtl/fixed_point_divider.sv
// Signed Q(WIDTH-FRAC).FRAC restoring divider, one quotient bit per clock, saturating.
// Define ROUND_NEAREST_EN to add a guard-bit iteration and round half away from zero.
module fixed_point_divider #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  fixed_point_divider_if.slave  bus
);

  localparam int N = WIDTH + FRAC;
`ifdef ROUND_NEAREST_EN
  localparam int ITER = N + 1;
  localparam int SH   = FRAC + 1;
`else
  localparam int ITER = N;
  localparam int SH   = FRAC;
`endif
  localparam int CW = $clog2(ITER + 1);
  localparam int MW = N + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0]    LAST_CNT = CW'(ITER - 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [WIDTH:0]   ONE_X    = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [MW-1:0]    QMAX_POS = {{(MW-WIDTH){1'b0}}, MAX_POS};
  localparam logic [MW-1:0]    QMAX_NEG = {{(MW-WIDTH){1'b0}}, MIN_NEG};

  logic [1:0]       state_q, state_d;
  logic             sign_q, sign_d;
  logic             a_neg_q, a_neg_d;
  logic             dz_q, dz_d;
  logic [WIDTH:0]   bmag_q, bmag_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [ITER-1:0]  dvd_q, dvd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   a_ext, b_ext, a_mag, b_mag;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] trial;
  logic             q_bit;
  logic [WIDTH-1:0] rem_step;
  logic [ITER-1:0]  dvd_step;
  logic [MW-1:0]    q_mag;
  logic [WIDTH-1:0] fin_result;
  logic             fin_ovf;

  // One extra magnitude bit keeps |-2^(WIDTH-1)| representable.
  always_comb begin
    a_ext = {bus.A[WIDTH-1], bus.A};
    b_ext = {bus.B[WIDTH-1], bus.B};
    a_mag = a_ext[WIDTH] ? (~a_ext + ONE_X) : a_ext;
    b_mag = b_ext[WIDTH] ? (~b_ext + ONE_X) : b_ext;
  end

  // Remainder stays below |B| <= 2^(WIDTH-1), so WIDTH bits hold it between steps.
  always_comb begin
    rem_sh   = {rem_q, dvd_q[ITER-1]};
    trial    = {1'b0, rem_sh} - {1'b0, bmag_q};
    q_bit    = ~trial[WIDTH+1];
    rem_step = q_bit ? WIDTH'(trial) : WIDTH'(rem_sh);
    dvd_step = {dvd_q[ITER-2:0], q_bit};
  end

  always_comb begin
`ifdef ROUND_NEAREST_EN
    q_mag = {1'b0, dvd_q[ITER-1:1]} + {{(MW-1){1'b0}}, dvd_q[0]};
`else
    q_mag = {1'b0, dvd_q};
`endif
    fin_result = '0;
    fin_ovf    = 1'b0;
    if (dz_q) begin
      fin_result = a_neg_q ? MIN_NEG : MAX_POS;
      fin_ovf    = 1'b1;
    end else if (!sign_q) begin
      if (q_mag > QMAX_POS) begin
        fin_result = MAX_POS;
        fin_ovf    = 1'b1;
      end else begin
        fin_result = q_mag[WIDTH-1:0];
      end
    end else begin
      if (q_mag > QMAX_NEG) begin
        fin_result = MIN_NEG;
        fin_ovf    = 1'b1;
      end else begin
        fin_result = ~q_mag[WIDTH-1:0] + ONE_W;
      end
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    a_neg_d  = a_neg_q;
    dz_d     = dz_q;
    bmag_d   = bmag_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    busy_d   = (state_q != S_IDLE);
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          sign_d  = bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
          a_neg_d = bus.A[WIDTH-1];
          bmag_d  = b_mag;
          dz_d    = (bus.B == '0);
          rem_d   = '0;
          cnt_d   = '0;
          dvd_d   = ITER'({a_mag, {SH{1'b0}}});
          state_d = (bus.B == '0) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        rem_d = rem_step;
        dvd_d = dvd_step;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == LAST_CNT) state_d = S_DONE;
      end
      S_DONE: begin
        result_d = fin_result;
        ovf_d    = fin_ovf;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sign_q   <= 1'b0;
      a_neg_q  <= 1'b0;
      dz_q     <= 1'b0;
      bmag_q   <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      a_neg_q  <= a_neg_d;
      dz_q     <= dz_d;
      bmag_q   <= bmag_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.result        = result_q;
  assign bus.overflow_flag = ovf_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;

endmodule

// File: tb/tb_fixed_point_divider.sv
// Directed and random checks of fixed_point_divider against an integer reference model.
// Define ROUND_NEAREST_EN here and in the RTL build to check the rounding variant.
module tb_fixed_point_divider;

  localparam int WIDTH = 16;
  localparam int FRAC  = 8;
  localparam int N     = WIDTH + FRAC;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             ovf;
    int               lat;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  fixed_point_divider_if #(.WIDTH(WIDTH)) bus ();

  fixed_point_divider #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t   e;
    longint am, bm, q;
    bit     neg;
    am  = longint'($signed(a));
    bm  = longint'($signed(b));
    neg = (am < 0) ^ (bm < 0);
    if (bm == 0) begin
      e.res = (am < 0) ? 16'h8000 : 16'h7FFF;
      e.ovf = 1'b1;
      e.lat = 1;
      return e;
    end
    if (am < 0) am = -am;
    if (bm < 0) bm = -bm;
`ifdef ROUND_NEAREST_EN
    q     = (((am << (FRAC + 1)) / bm) + 1) >> 1;
    e.lat = N + 2;
`else
    q     = (am << FRAC) / bm;
    e.lat = N + 1;
`endif
    e.ovf = 1'b0;
    if (!neg) begin
      if (q > 32767) begin e.res = 16'h7FFF; e.ovf = 1'b1; end
      else e.res = 16'(q);
    end else begin
      if (q > 32768) begin e.res = 16'h8000; e.ovf = 1'b1; end
      else e.res = 16'(-q);
    end
    return e;
  endfunction

  // Issue one division, optionally pulse start while busy, then compare against the scoreboard.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input string tag, input int pulse_at);
    exp_t e;
    int   cyc;
    bit   seen;
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    sb.push_back(model(a, b));
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.A     = 16'($urandom);
    bus.B     = 16'($urandom);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) check({tag, " busy_rise"}, 32'(bus.busy), 32'(1));
      bus.start = (pulse_at != 0 && cyc == pulse_at);
      if (bus.done) seen = 1'b1;
    end
    bus.start = 1'b0;
    e = sb.pop_front();
    check({tag, " done_seen"}, 32'(seen), 32'(1));
    if (seen) begin
      check({tag, " latency"}, 32'(cyc), 32'(e.lat));
      check({tag, " result"}, 32'(bus.result), 32'(e.res));
      check({tag, " overflow"}, 32'(bus.overflow_flag), 32'(e.ovf));
      check({tag, " busy_in_done"}, 32'(bus.busy), 32'(1));
    end
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (bus.done) n++;
    end
  endtask

  initial begin
    int   nd;
    logic [WIDTH-1:0] ra, rb;
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset result", 32'(bus.result), 32'(0));
    check("reset overflow", 32'(bus.overflow_flag), 32'(0));
    check("reset busy", 32'(bus.busy), 32'(0));
    check("reset done", 32'(bus.done), 32'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(16'h0300, 16'h0200, "3/2", 0);
    run_op(16'hFD00, 16'h0200, "-3/2", 0);

    // Abort a division ten cycles in; nothing may complete afterwards.
    bus.A     = 16'h7F00;
    bus.B     = 16'h0010;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort result", 32'(bus.result), 32'(0));
    check("abort overflow", 32'(bus.overflow_flag), 32'(0));
    check("abort busy", 32'(bus.busy), 32'(0));
    check("abort done", 32'(bus.done), 32'(0));
    count_dones(40, nd);
    check("abort no_done", 32'(nd), 32'(0));

    run_op(16'h7F00, 16'h0010, "pos_sat", 0);
    run_op(16'h8000, 16'h0100, "min_exact", 0);
    run_op(16'h0100, 16'h0000, "div0_pos", 0);
    run_op(16'hFF00, 16'h0000, "div0_neg", 0);
    run_op(16'h0000, 16'h0000, "div0_zero", 0);
    run_op(16'h0200, 16'h0300, "2/3_pulse", 5);
    count_dones(30, nd);
    check("pulse no_extra_done", 32'(nd), 32'(0));
    run_op(16'h0000, 16'hFE00, "zero_num", 0);
    run_op(16'h8000, 16'hFF00, "min_by_neg1", 0);
    run_op(16'h0001, 16'h7FFF, "tiny", 0);

    for (int i = 0; i < 100; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 4 == 1) rb = 16'($urandom_range(0, 16'h01FF));
      if (i % 4 == 2) rb = -16'($urandom_range(1, 16'h01FF));
      run_op(ra, rb, $sformatf("rand%0d a=%h b=%h", i, ra, rb), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fixed_point_divider.md
Name: fixed_point_divider

Overview:
- Sequential signed fixed-point divider. It is the inverse operation of the team's combinational multiplier.
- Computes result = A / B in the same two's-complement Q format.
- Uses the same overflow-flag convention as the multiplier.
- Feeds the ODE accelerator datapath wherever step-size or coefficient division is needed.
- Restoring division, one quotient bit per clock, start/done handshake.

Parameters:
- WIDTH, 16, total operand/result width in bits, signed two's complement.
- FRAC, 8, fractional bits; Q(WIDTH-FRAC).FRAC, default Q8.8.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  dividend; captured on accepted start.
- B  input  WIDTH  divisor; captured on accepted start.
- result  output  WIDTH  quotient; held until next done.
- overflow_flag  output  1  saturation or divide-by-zero; held with result.
- busy  output  1  high from the cycle after an accepted start through the DONE cycle.
- done  output  1  one-cycle pulse; result and overflow_flag are valid from this cycle.

Behaviour:
- Reset: state=IDLE; result=0, overflow_flag=0, busy=0, done=0; counter and internal registers cleared.
- rst has priority over all other inputs and aborts any division in progress. No done is issued for an aborted division.
- N = WIDTH+FRAC (24 by default). N is the number of iterations.
- The counter is sized clog2(N+1).

IDLE:
- If start=1: capture sign = A[msb]^B[msb], |A| and |B|.
- Compute magnitudes with WIDTH+1 bits so that -2^(WIDTH-1) is representable.
- If B=0, go to DONE. Otherwise load the dividend register = |A|<<FRAC (N bits), clear the remainder, counter=0, and go to CALC.

CALC (N cycles):
- Shift {remainder, dividend} left by 1.
- Trial-subtract |B|. If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
- After iteration N, go to DONE.

DONE (1 cycle):
- Register result and overflow_flag; done=1; next state IDLE.
- busy is still 1 in this cycle and drops to 0 in the following IDLE cycle.

Latency:
- Accepted start at edge k gives done at edge k+N+1 (k+25 by default).
- For divide-by-zero, done is at edge k+1.
- Back-to-back operation: start may be asserted in the IDLE cycle right after done.
- start while busy is ignored (not queued).
- A and B may change freely after capture.

Arithmetic:
- Quotient magnitude Q (N bits), truncated toward zero.
- Positive result: if Q > 2^(WIDTH-1)-1, result=0x7FFF and overflow=1.
- Negative result: if Q > 2^(WIDTH-1), result=0x8000 and overflow=1. Otherwise result = -Q, so -2^(WIDTH-1) is exact with no overflow.
- A zero quotient always gives result 0 with no sign issue.
- Divide-by-zero: overflow=1. result=0x7FFF if A >= 0, 0x8000 if A < 0 (A=0 gives 0x7FFF).

Optional Feature:
- Macro ROUND_NEAREST_EN.
- Defined: CALC runs N+1 iterations; the extra bit is the guard bit. Q is incremented when the guard bit is 1, i.e. rounding is half away from zero on the magnitude, applied before saturation. Latency becomes N+2 (divide-by-zero latency is unchanged).
- Undefined: truncation toward zero, latency N+1.

Test Plan:
- Reset mid-CALC (assert rst at cycle 10 after start) -> next cycle result=0, flags 0, busy=0, no done pulse.
- A=0x0300 (3.0), B=0x0200 (2.0), start -> done exactly 25 cycles later; result=0x0180, overflow=0. Repeat with A=0xFD00 -> result=0xFE80.
- A=0x7F00, B=0x0010 -> result=0x7FFF, overflow=1. Then A=0x8000, B=0x0100 -> result=0x8000, overflow=0.
- A=0x0100, B=0x0000 -> done 1 cycle after start, result=0x7FFF, overflow=1. A=0xFF00, B=0 -> 0x8000, overflow=1.
- A=0x0200, B=0x0300 -> result 0x00AA (0x00AB with ROUND_NEAREST_EN, done at 26 cycles). start pulsed during busy has no effect.
- Regression: 100 random vectors from a file, compared against a golden model; print the index on mismatch; both macro settings.
